// File: rtl/axi_slave_ram.sv
// AXI-lite-style slave data memory: byte-strobed word array behind independent
// write (AW/W -> B) and read (AR -> R) engines, with out-of-range error responses.
module axi_slave_ram #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic                  awid,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  bresp,
  output logic                  bid,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_W-1:0]     araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rresp
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  typedef struct packed {
    logic              id;
    logic [ADDR_W-1:0] addr;
  } aw_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } w_req_t;

  typedef enum logic {W_COLLECT, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA}    r_state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic     aw_held_q, aw_held_d, w_held_q, w_held_d;
  aw_req_t  aw_q, aw_d;
  w_req_t   w_q, w_d;
  logic     bvalid_q, bvalid_d, bresp_q, bresp_d, bid_q, bid_d;
  logic     rvalid_q, rvalid_d, rresp_q, rresp_d, rd_ok_q, rd_ok_d;
  logic [DATA_W-1:0] rd_word_q, rd_word_d;

  logic [ADDR_W-1:0] w_word, r_word;
  logic [IDX_W-1:0]  w_idx, r_idx;
  logic              w_in_range, r_in_range, commit, ar_fire;

  // Offset is taken only after the lower-bound check, so a below-base address
  // that wraps to a small offset is still rejected.
  always_comb begin
    w_word     = (aw_q.addr - BASE_ADDR) >> OFF_W;
    r_word     = (araddr - BASE_ADDR) >> OFF_W;
    w_in_range = (aw_q.addr >= BASE_ADDR) && ((w_word >> IDX_W) == '0);
    r_in_range = (araddr >= BASE_ADDR) && ((r_word >> IDX_W) == '0);
    w_idx      = w_word[IDX_W-1:0];
    r_idx      = r_word[IDX_W-1:0];
  end

  // Write engine
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_d      = aw_q;
    w_d       = w_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    awready   = (w_state_q == W_COLLECT) && !aw_held_q;
    wready    = (w_state_q == W_COLLECT) && !w_held_q;
    commit    = (w_state_q == W_COLLECT) && aw_held_q && w_held_q;
    case (w_state_q)
      W_COLLECT: begin
        if (commit) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = !w_in_range;
          bid_d     = aw_q.id;
          w_state_d = W_RESP;
        end else begin
          if (awvalid && awready) begin
            aw_held_d = 1'b1;
            aw_d      = '{id: awid, addr: awaddr};
          end
          if (wvalid && wready) begin
            w_held_d = 1'b1;
            w_d      = '{data: wdata, strb: wstrb};
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_COLLECT;
        end
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  // Read engine; the array read uses pre-edge contents, giving read-before-write
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rd_ok_d   = rd_ok_q;
    rd_word_d = rd_word_q;
    arready   = (r_state_q == R_IDLE);
    ar_fire   = arvalid && arready;
    case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          rvalid_d  = 1'b1;
          rresp_d   = !r_in_range;
          rd_ok_d   = r_in_range;
          rd_word_d = mem[r_idx];
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_COLLECT;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_q      <= '0;
      w_q       <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 1'b0;
      bid_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 1'b0;
      rd_ok_q   <= 1'b0;
      rd_word_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_q      <= aw_d;
      w_q       <= w_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rd_ok_q   <= rd_ok_d;
      rd_word_q <= rd_word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit && w_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_q.strb[b]) mem[w_idx][8*b +: 8] <= w_q.data[8*b +: 8];
      end
    end
  end

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign bid    = bid_q;
  assign rvalid = rvalid_q;
  assign rresp  = rresp_q;
  assign rdata  = rd_ok_q ? rd_word_q : '0;

endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed bench for axi_slave_ram: handshakes, strobes, back-pressure,
// range errors, read/write collision and reset while a response is pending.
module tb_axi_slave_ram;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 64;
  localparam logic [31:0] BASE   = 32'h8000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              awvalid, awready, awid;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic [7:0]        wstrb;
  logic              bvalid, bready, bresp, bid;
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic              rresp;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  axi_slave_ram dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  // Drivers only: stimulus changes and sampling both happen at negedge.
  task automatic write_word(input logic id, input logic [31:0] addr,
                            input logic [63:0] data, input logic [7:0] strb,
                            output logic v, output logic resp, output logic rid);
    awvalid = 1'b1; awid = id; awaddr = addr;
    wvalid  = 1'b1; wdata = data; wstrb = strb;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    v = bvalid; resp = bresp; rid = bid;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic read_word(input logic [31:0] addr, output logic v,
                           output logic resp, output logic [63:0] data);
    arvalid = 1'b1; araddr = addr;
    @(negedge clk);
    arvalid = 1'b0;
    v = rvalid; resp = rresp; data = rdata;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    awvalid = 0; awid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0;
    bready = 0; arvalid = 0; araddr = '0; rready = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vec++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, bid, rresp} !== 8'b1110_0000) begin
      errs++;
      $display("FAIL reset_ctrl: got aw/w/ar/bv/rv/br/bid/rr=%b want 11100000",
               {awready, wready, arready, bvalid, rvalid, bresp, bid, rresp});
    end
    vec++;
    if (rdata !== 64'h0) begin
      errs++; $display("FAIL reset_rdata: got %h want 0", rdata);
    end
  endtask

  task automatic test_write_read;
    logic v, resp;
    logic [63:0] d;
    awvalid = 1'b1; awid = 1'b1; awaddr = BASE + 32'd8;
    wvalid  = 1'b1; wdata = 64'h1122_3344_5566_7788; wstrb = 8'hFF;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    vec++;
    if (bvalid !== 1'b0) begin
      errs++; $display("FAIL wr_latency_early: bvalid=%b want 0", bvalid);
    end
    @(negedge clk);
    vec++;
    if ({bvalid, bresp, bid} !== 3'b101) begin
      errs++; $display("FAIL wr_resp: bvalid/bresp/bid=%b want 101", {bvalid, bresp, bid});
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    vec++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      errs++; $display("FAIL b_release: bvalid/awready/wready=%b want 011", {bvalid, awready, wready});
    end
    read_word(BASE + 32'd8, v, resp, d);
    vec++;
    if ({v, resp} !== 2'b10 || d !== 64'h1122_3344_5566_7788) begin
      errs++; $display("FAIL rd_back: v=%b resp=%b data=%h want 1 0 1122334455667788", v, resp, d);
    end
  endtask

  task automatic test_strobe_w_first;
    logic v, resp;
    logic [63:0] d;
    wvalid = 1'b1; wdata = 64'hAAAA_AAAA_AAAA_AAAA; wstrb = 8'h0F;
    @(negedge clk);
    wvalid = 1'b0;
    vec++;
    if ({wready, awready} !== 2'b01) begin
      errs++; $display("FAIL w_held: wready/awready=%b want 01", {wready, awready});
    end
    @(negedge clk);
    @(negedge clk);
    awvalid = 1'b1; awid = 1'b0; awaddr = BASE + 32'd8;
    @(negedge clk);
    awvalid = 1'b0;
    @(negedge clk);
    vec++;
    if ({bvalid, bresp, bid} !== 3'b100) begin
      errs++; $display("FAIL strb_resp: bvalid/bresp/bid=%b want 100", {bvalid, bresp, bid});
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    read_word(BASE + 32'd8, v, resp, d);
    vec++;
    if ({v, resp} !== 2'b10 || d !== 64'h1122_3344_AAAA_AAAA) begin
      errs++; $display("FAIL strb_data: v=%b resp=%b data=%h want 1 0 11223344aaaaaaaa", v, resp, d);
    end
  endtask

  task automatic test_backpressure;
    logic v, resp;
    logic [63:0] d;
    awvalid = 1'b1; awid = 1'b1; awaddr = BASE + 32'd16;
    wvalid  = 1'b1; wdata = 64'hDEAD_BEEF_0123_4567; wstrb = 8'hFF;
    arvalid = 1'b1; araddr = BASE + 32'd8;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      vec++;
      if ({bvalid, bresp, bid, rvalid, rresp, awready, wready, arready} !== 8'b1011_0000 ||
          rdata !== 64'h1122_3344_AAAA_AAAA) begin
        errs++;
        $display("FAIL bp_hold[%0d]: bv/br/bid/rv/rr/awr/wr/arr=%b rdata=%h want 10110000 11223344aaaaaaaa",
                 i, {bvalid, bresp, bid, rvalid, rresp, awready, wready, arready}, rdata);
      end
      @(negedge clk);
    end
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    vec++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin
      errs++; $display("FAIL bp_release: bv/rv/awr/wr/arr=%b want 00111",
                       {bvalid, rvalid, awready, wready, arready});
    end
    read_word(BASE + 32'd16, v, resp, d);
    vec++;
    if ({v, resp} !== 2'b10 || d !== 64'hDEAD_BEEF_0123_4567) begin
      errs++; $display("FAIL bp_data: v=%b resp=%b data=%h want 1 0 deadbeef01234567", v, resp, d);
    end
  endtask

  task automatic test_out_of_range;
    logic v, resp, rid;
    logic [63:0] d;
    // Seed the words an unchecked decode would alias onto.
    write_word(1'b0, BASE + 32'h1FF8, 64'hCAFE_F00D_1234_5678, 8'hFF, v, resp, rid);
    write_word(1'b0, BASE, 64'h5555_5555_5555_5555, 8'hFF, v, resp, rid);
    write_word(1'b1, BASE - 32'd8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, v, resp, rid);
    vec++;
    if ({v, resp, rid} !== 3'b111) begin
      errs++; $display("FAIL oor_wr_resp: bvalid/bresp/bid=%b want 111", {v, resp, rid});
    end
    read_word(BASE + 32'h1FF8, v, resp, d);
    vec++;
    if ({v, resp} !== 2'b10 || d !== 64'hCAFE_F00D_1234_5678) begin
      errs++; $display("FAIL oor_wr_nochange: v=%b resp=%b data=%h want 1 0 cafef00d12345678", v, resp, d);
    end
    read_word(BASE + 32'h2000, v, resp, d);
    vec++;
    if ({v, resp} !== 2'b11 || d !== 64'h0) begin
      errs++; $display("FAIL oor_rd_top: v=%b resp=%b data=%h want 1 1 0", v, resp, d);
    end
    read_word(32'h0000_0000, v, resp, d);
    vec++;
    if ({v, resp} !== 2'b11 || d !== 64'h0) begin
      errs++; $display("FAIL oor_rd_zero: v=%b resp=%b data=%h want 1 1 0", v, resp, d);
    end
    read_word(BASE + 32'h1FFF, v, resp, d);
    vec++;
    if ({v, resp} !== 2'b10 || d !== 64'hCAFE_F00D_1234_5678) begin
      errs++; $display("FAIL last_byte_in_range: v=%b resp=%b data=%h want 1 0 cafef00d12345678", v, resp, d);
    end
  endtask

  task automatic test_collision;
    logic v, resp, rid;
    logic [63:0] d;
    write_word(1'b0, BASE + 32'd24, 64'h0101_0101_0101_0101, 8'hFF, v, resp, rid);
    awvalid = 1'b1; awid = 1'b0; awaddr = BASE + 32'd24;
    wvalid  = 1'b1; wdata = 64'h0202_0202_0202_0202; wstrb = 8'hFF;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b1; araddr = BASE + 32'd24;
    @(negedge clk);
    arvalid = 1'b0;
    vec++;
    if ({bvalid, rvalid, rresp} !== 3'b110 || rdata !== 64'h0101_0101_0101_0101) begin
      errs++; $display("FAIL collide_old: bv/rv/rr=%b rdata=%h want 110 0101010101010101",
                       {bvalid, rvalid, rresp}, rdata);
    end
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    read_word(BASE + 32'd24, v, resp, d);
    vec++;
    if ({v, resp} !== 2'b10 || d !== 64'h0202_0202_0202_0202) begin
      errs++; $display("FAIL collide_new: v=%b resp=%b data=%h want 1 0 0202020202020202", v, resp, d);
    end
  endtask

  task automatic test_reset_pending;
    awvalid = 1'b1; awid = 1'b1; awaddr = BASE + 32'd32;
    wvalid  = 1'b1; wdata = 64'h7; wstrb = 8'hFF;
    arvalid = 1'b1; araddr = BASE + 32'd8;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    vec++;
    if ({bvalid, rvalid} !== 2'b11) begin
      errs++; $display("FAIL pre_reset_pending: bvalid/rvalid=%b want 11", {bvalid, rvalid});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec++;
    if ({bvalid, rvalid, bid, awready, wready, arready} !== 6'b000111 || rdata !== 64'h0) begin
      errs++; $display("FAIL reset_drop: bv/rv/bid/awr/wr/arr=%b rdata=%h want 000111 0",
                       {bvalid, rvalid, bid, awready, wready, arready}, rdata);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_strobe_w_first;
    test_backpressure;
    test_out_of_range;
    test_collision;
    test_reset_pending;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/axi_slave_ram.md
Name: axi_slave_ram

Overview:
- AXI-lite-style slave data memory directly downstream of the core's AXI interconnect.
- Consumes the AW/W/B/AR/R channels the interconnect drives for core loads and stores.
- Stores data in an internal synchronous word array with byte strobes and returns write/read responses.
- Out-of-range accesses return an error response and never stall the bus.

Parameters:
ADDR_W, 32, address width of awaddr/araddr
DATA_W, 64, data width; must be a power of two, >= 8
DEPTH, 1024, number of DATA_W-bit words; power of two
BASE_ADDR, 32'h8000_0000, byte address of word 0

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
awvalid  in  1  write address valid
awready  out  1  write address ready
awid  in  1  write ID; returned unchanged on bid
awaddr  in  ADDR_W  write byte address
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte enables
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  1  0 = OKAY, 1 = error (out of range)
bid  out  1  ID of the completed write
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  ADDR_W  read byte address
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  DATA_W  read data
rresp  out  1  0 = OKAY, 1 = error

Behaviour:
- Reset (rst=1 at an edge): awready=wready=arready=1, bvalid=rvalid=0, bresp=rresp=0, bid=0, rdata=0. All holding flags cleared; both FSMs return to IDLE. Memory contents are not reset. Reset mid-transaction drops any pending response.
- Address decode:
  - Word index = (addr - BASE_ADDR) >> log2(DATA_W/8).
  - Low byte-offset bits are ignored; no alignment error.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + DEPTH*DATA_W/8. Compare with ADDR_W-bit unsigned arithmetic; the subtraction must not wrap into range.
- Write FSM, states W_COLLECT and W_RESP:
  - W_COLLECT: AW and W are accepted independently, in any order or in the same cycle, into one-entry holding registers (aw_held, w_held).
  - awready = !aw_held in W_COLLECT; wready = !w_held in W_COLLECT. Both are 0 in W_RESP.
  - On an edge where aw_held and w_held are both set at the start of the cycle: commit. If in range, write each byte lane whose wstrb bit is 1. Set bresp=!in_range, bid=held awid, bvalid=1. Clear the holding flags. Go to W_RESP.
  - Minimum latency: AW+W handshake at edge N gives bvalid=1 after edge N+1.
  - W_RESP: hold bvalid, bresp and bid stable until bvalid&&bready. At that edge: bvalid=0, return to W_COLLECT, awready=wready=1.
  - wstrb=0 in range gives OKAY with no memory change.
- Read FSM, states R_IDLE and R_DATA:
  - arready = (state==R_IDLE).
  - AR handshake at edge N: the memory is read synchronously at that edge. rdata=mem[idx] if in range, else 0. rresp=!in_range. rvalid=1 after edge N. Go to R_DATA.
  - R_DATA: rdata and rresp stay stable while rvalid && !rready. When rvalid&&rready: rvalid=0, back to R_IDLE.
  - A new AR handshake is possible on the edge after the R handshake.
- Simultaneous events:
  - Read and write paths are fully independent and may be active in the same cycle.
  - Read sampled on the same edge as a write commit to the same word returns the OLD data (read-before-write).
  - A read sampled on any later edge returns the new data.
- No outstanding-transaction queue: at most one write and one read are in flight.

Test Plan:
- Reset then idle: awready=wready=arready=1, bvalid=rvalid=0. Reset asserted while bvalid=1 -> bvalid=0 on the next edge.
- Write, then read back:
  - AW and W handshaked in the same cycle: awaddr=BASE_ADDR+8, wdata=64'h1122_3344_5566_7788, wstrb=8'hFF, awid=1.
  - Required: bvalid two edges later, bresp=0, bid=1.
  - AR to the same address -> rvalid one edge after the AR handshake, rdata=64'h1122_3344_5566_7788, rresp=0.
- Byte strobes with W before AW:
  - Send W alone (wdata=64'hAAAA_AAAA_AAAA_AAAA, wstrb=8'h0F); wready drops to 0 and awready stays 1.
  - Send AW three cycles later -> commit occurs.
  - Readback = 64'h1122_3344_AAAA_AAAA.
- Back-pressure: hold bready=0 and rready=0 for 5 cycles -> bvalid, rvalid, bresp, rdata stay stable, and awready=wready=arready=0 throughout. Release -> handshake completes in one edge.
- Out of range:
  - awaddr=BASE_ADDR-8 -> bresp=1, memory unchanged.
  - araddr=BASE_ADDR+DEPTH*8 -> rresp=1, rdata=0.
  - araddr=32'h0000_0000 with BASE_ADDR=32'h8000_0000 -> rresp=1.
- Same-word collision: AR handshake on the commit edge of a write to the same word -> old data returned. An AR on the next edge returns the new data.
